// File: rtl/risc_pkg.sv
// Shared definitions for the small RISC datapath: opcode encodings, default
// widths and the run-control FSM state type.
package risc_pkg;

  localparam int unsigned AWIDTH_DEF = 5;
  localparam int unsigned DWIDTH_DEF = 8;

  // 3-bit opcode field, IR[7:5] with the default widths.
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } run_state_t;

endpackage

// File: rtl/run_ctrl.sv
// Run/halt/single-step/breakpoint control.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   sel, ld_ir, halt  controller strobes (edge-detected here)
//   resume, step      debug controls, sampled in HALTED
//   bp_en, bp_addr    breakpoint enable / PC value
//   pc                current program counter
//   ld_ir_rise        first cycle of an ld_ir pulse
//   run               controller clock enable
//   halted, bp_hit    status
module run_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned AWIDTH       = AWIDTH_DEF,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              ld_ir,
  input  logic              halt,
  input  logic              resume,
  input  logic              step,
  input  logic              bp_en,
  input  logic [AWIDTH-1:0] bp_addr,
  input  logic [AWIDTH-1:0] pc,
  output logic              ld_ir_rise,
  output logic              run,
  output logic              halted,
  output logic              bp_hit
);

  localparam run_state_t RstState = START_HALTED ? HALTED : RUN;

  run_state_t state_q, state_d;
  logic       bp_hit_q, bp_hit_d;
  logic       sel_q, ld_ir_q, halt_q;
  logic       boundary, halt_rise, bp_match;

  // sel_q resets to 1 so leaving reset with sel=1 is not a boundary.
  assign boundary   = sel & ~sel_q;
  assign halt_rise  = halt & ~halt_q;
  assign ld_ir_rise = ld_ir & ~ld_ir_q;
  assign bp_match   = bp_en & boundary & (pc == bp_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RstState;
      bp_hit_q <= 1'b0;
      sel_q    <= 1'b1;
      ld_ir_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bp_hit_q <= bp_hit_d;
      sel_q    <= sel;
      ld_ir_q  <= ld_ir;
      halt_q   <= halt;
    end
  end

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    run      = 1'b0;
    case (state_q)
      RUN: begin
        // Halt edge still lets this cycle run, so the controller reaches OP_FETCH.
        run = ~bp_match;
        if (halt_rise) state_d = HALTED;
        if (bp_match) begin
          state_d  = HALTED;
          bp_hit_d = 1'b1;
        end
      end
      HALTED: begin
        if (resume) begin
          state_d  = RUN;
          bp_hit_d = 1'b0;
        end else if (step) begin
          state_d  = STEP;
          bp_hit_d = 1'b0;
        end
      end
      STEP: begin
        // Freeze at the start of the next instruction; breakpoints ignored.
        run = ~boundary;
        if (boundary || halt_rise) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  assign halted = (state_q == HALTED);
  assign bp_hit = bp_hit_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: program counter, instruction register, retired-instruction
// counter and memory address mux, plus run control for the controller.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   sel, ld_ir, inc_pc, ld_pc  controller strobes
//   halt                       halt request from controller
//   data_in                    memory read data
//   resume, step               debug controls
//   bp_en, bp_addr             breakpoint
//   opcode, operand            IR fields
//   addr                       memory address (sel ? pc : operand)
//   pc                         program counter
//   run, halted, bp_hit        run control outputs
//   instr_count                IR captures since reset
module fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned AWIDTH       = AWIDTH_DEF,
  parameter int unsigned DWIDTH       = DWIDTH_DEF,
  parameter int unsigned CWIDTH       = 16,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel,
  input  logic                     ld_ir,
  input  logic                     inc_pc,
  input  logic                     ld_pc,
  input  logic                     halt,
  input  logic [DWIDTH-1:0]        data_in,
  input  logic                     resume,
  input  logic                     step,
  input  logic                     bp_en,
  input  logic [AWIDTH-1:0]        bp_addr,
  output logic [DWIDTH-AWIDTH-1:0] opcode,
  output logic [AWIDTH-1:0]        operand,
  output logic [AWIDTH-1:0]        addr,
  output logic [AWIDTH-1:0]        pc,
  output logic                     run,
  output logic                     halted,
  output logic                     bp_hit,
  output logic [CWIDTH-1:0]        instr_count
);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              ld_ir_rise;

  run_ctrl #(
    .AWIDTH       (AWIDTH),
    .START_HALTED (START_HALTED)
  ) u_run_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .ld_ir      (ld_ir),
    .halt       (halt),
    .resume     (resume),
    .step       (step),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc_q),
    .ld_ir_rise (ld_ir_rise),
    .run        (run),
    .halted     (halted),
    .bp_hit     (bp_hit)
  );

  assign opcode  = ir_q[DWIDTH-1:AWIDTH];
  assign operand = ir_q[AWIDTH-1:0];

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;
    if (run) begin
      if (ld_pc)       pc_d = operand;
      else if (inc_pc) pc_d = pc_q + 1'b1;
      // Second phase of ld_ir carries invalid data; capture only the first.
      if (ld_ir_rise) begin
        ir_d  = data_in;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign addr        = sel ? pc_q : operand;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk, rst_n;
  logic        sel, ld_ir, inc_pc, ld_pc, halt, resume, step, bp_en;
  logic [7:0]  data_in;
  logic [4:0]  bp_addr;
  logic [2:0]  opcode;
  logic [4:0]  operand, addr, pc;
  logic        run, halted, bp_hit;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .ld_ir       (ld_ir),
    .inc_pc      (inc_pc),
    .ld_pc       (ld_pc),
    .halt        (halt),
    .data_in     (data_in),
    .resume      (resume),
    .step        (step),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .opcode      (opcode),
    .operand     (operand),
    .addr        (addr),
    .pc          (pc),
    .run         (run),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b1; ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0; halt = 1'b0;
    data_in = 8'h00; resume = 1'b0; step = 1'b0; bp_en = 1'b0; bp_addr = 5'd0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    inc_pc = 1'b1;
    repeat (7) cyc();
    inc_pc = 1'b0;
    n_cmp++; if (pc !== 5'd7) begin n_bad++; $display("FAIL pre_reset_pc got %0d want 7", pc); end
    ld_ir = 1'b1; data_in = 8'h45;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 5'd0) begin n_bad++; $display("FAIL rst_pc got %0d want 0", pc); end
    n_cmp++; if (opcode !== 3'd0) begin n_bad++; $display("FAIL rst_opcode got %0d want 0", opcode); end
    n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", instr_count); end
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL rst_run got %b want 1", run); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got %b want 0", halted); end
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL rst_bp_hit got %b want 0", bp_hit); end
    n_cmp++; if (addr !== 5'd0) begin n_bad++; $display("FAIL rst_addr got %0d want 0", addr); end
    ld_ir = 1'b0; data_in = 8'h00;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fetch();
    ld_ir = 1'b1; data_in = 8'h45; cyc();
    data_in = 8'h99; cyc();
    ld_ir = 1'b0;
    n_cmp++; if ({opcode, operand} !== 8'h45) begin n_bad++; $display("FAIL fetch_ir got %h want 45", {opcode, operand}); end
    n_cmp++; if (opcode !== 3'd2) begin n_bad++; $display("FAIL fetch_opcode got %0d want 2", opcode); end
    n_cmp++; if (operand !== 5'd5) begin n_bad++; $display("FAIL fetch_operand got %0d want 5", operand); end
    n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL fetch_count got %0d want 1", instr_count); end
    sel = 1'b0; #1;
    n_cmp++; if (addr !== 5'd5) begin n_bad++; $display("FAIL addr_operand got %0d want 5", addr); end
    sel = 1'b1; #1;
    n_cmp++; if (addr !== 5'd0) begin n_bad++; $display("FAIL addr_pc got %0d want 0", addr); end
    inc_pc = 1'b1; cyc();
    n_cmp++; if (pc !== 5'd1) begin n_bad++; $display("FAIL inc_pc got %0d want 1", pc); end
    ld_pc = 1'b1; cyc();
    ld_pc = 1'b0; inc_pc = 1'b0;
    n_cmp++; if (pc !== 5'd5) begin n_bad++; $display("FAIL ld_pc_prio got %0d want 5", pc); end
    ld_ir = 1'b1; data_in = 8'h1F; cyc();
    ld_ir = 1'b0; ld_pc = 1'b1; cyc();
    ld_pc = 1'b0;
    n_cmp++; if (pc !== 5'd31) begin n_bad++; $display("FAIL ld_pc_31 got %0d want 31", pc); end
    inc_pc = 1'b1; cyc();
    inc_pc = 1'b0;
    n_cmp++; if (pc !== 5'd0) begin n_bad++; $display("FAIL pc_wrap got %0d want 0", pc); end
    n_cmp++; if (instr_count !== 16'd2) begin n_bad++; $display("FAIL fetch_count2 got %0d want 2", instr_count); end
  endtask

  task automatic test_halt();
    ld_ir = 1'b1; data_in = 8'h03; cyc();
    ld_ir = 1'b0; ld_pc = 1'b1; cyc();
    ld_pc = 1'b0;
    n_cmp++; if (pc !== 5'd3) begin n_bad++; $display("FAIL halt_setup_pc got %0d want 3", pc); end
    halt = 1'b1; inc_pc = 1'b1; #1;
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL halt_edge_run got %b want 1", run); end
    cyc();
    n_cmp++; if (pc !== 5'd4) begin n_bad++; $display("FAIL halt_pc got %0d want 4", pc); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_halted got %b want 1", halted); end
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL halt_run got %b want 0", run); end
    ld_pc = 1'b1; ld_ir = 1'b1; data_in = 8'h77; cyc();
    ld_pc = 1'b0; inc_pc = 1'b0; ld_ir = 1'b0;
    n_cmp++; if (pc !== 5'd4) begin n_bad++; $display("FAIL halted_pc_frozen got %0d want 4", pc); end
    n_cmp++; if ({opcode, operand} !== 8'h03) begin n_bad++; $display("FAIL halted_ir_frozen got %h want 03", {opcode, operand}); end
    n_cmp++; if (instr_count !== 16'd3) begin n_bad++; $display("FAIL halted_count got %0d want 3", instr_count); end
    resume = 1'b1; cyc();
    resume = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL resume_halted got %b want 0", halted); end
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL resume_run got %b want 1", run); end
    cyc();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL no_rehalt got %b want 0", halted); end
    halt = 1'b0; cyc();
  endtask

  task automatic test_step();
    halt = 1'b1; cyc();
    halt = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL step_pre_halted got %b want 1", halted); end
    step = 1'b1; cyc();
    step = 1'b0;
    n_cmp++; if (halted !== 1'b0 || run !== 1'b1) begin n_bad++; $display("FAIL step_enter got halted=%b run=%b want 0/1", halted, run); end
    sel = 1'b0; cyc();
    ld_ir = 1'b1; data_in = 8'h62; cyc();
    data_in = 8'h00; cyc();
    ld_ir = 1'b0;
    n_cmp++; if (instr_count !== 16'd4) begin n_bad++; $display("FAIL step_count got %0d want 4", instr_count); end
    n_cmp++; if ({opcode, operand} !== 8'h62) begin n_bad++; $display("FAIL step_ir got %h want 62", {opcode, operand}); end
    inc_pc = 1'b1; cyc();
    sel = 1'b1; #1;
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL step_boundary_run got %b want 0", run); end
    cyc();
    inc_pc = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL step_end_halted got %b want 1", halted); end
    n_cmp++; if (pc !== 5'd5) begin n_bad++; $display("FAIL step_pc got %0d want 5", pc); end
    n_cmp++; if (instr_count !== 16'd4) begin n_bad++; $display("FAIL step_one_capture got %0d want 4", instr_count); end
  endtask

  task automatic test_breakpoint();
    resume = 1'b1; cyc();
    resume = 1'b0;
    bp_en = 1'b1; bp_addr = 5'd6;
    sel = 1'b0; cyc();
    ld_ir = 1'b1; data_in = 8'hE6; cyc();
    ld_ir = 1'b0; ld_pc = 1'b1; cyc();
    ld_pc = 1'b0;
    n_cmp++; if (pc !== 5'd6) begin n_bad++; $display("FAIL bp_jmp_pc got %0d want 6", pc); end
    sel = 1'b1; #1;
    n_cmp++; if (run !== 1'b0) begin n_bad++; $display("FAIL bp_run got %b want 0", run); end
    cyc();
    n_cmp++; if (halted !== 1'b1 || bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_halt got halted=%b bp_hit=%b want 1/1", halted, bp_hit); end
    resume = 1'b1; cyc();
    resume = 1'b0;
    n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_clear got %b want 0", bp_hit); end
    n_cmp++; if (halted !== 1'b0 || run !== 1'b1) begin n_bad++; $display("FAIL bp_resume got halted=%b run=%b want 0/1", halted, run); end
    n_cmp++; if (pc !== 5'd6) begin n_bad++; $display("FAIL bp_resume_pc got %0d want 6", pc); end
    inc_pc = 1'b1; cyc();
    inc_pc = 1'b0;
    n_cmp++; if (pc !== 5'd7 || halted !== 1'b0) begin n_bad++; $display("FAIL bp_continue got pc=%0d halted=%b want 7/0", pc, halted); end
    sel = 1'b0; cyc();
    sel = 1'b1; #1;
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL bp_other_addr_run got %b want 1", run); end
    cyc();
    bp_en = 1'b0;
  endtask

  task automatic test_resume_step();
    halt = 1'b1; cyc();
    halt = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL rs_pre_halted got %b want 1", halted); end
    resume = 1'b1; step = 1'b1; cyc();
    resume = 1'b0; step = 1'b0;
    n_cmp++; if (halted !== 1'b0 || run !== 1'b1) begin n_bad++; $display("FAIL rs_leave got halted=%b run=%b want 0/1", halted, run); end
    // In RUN (not STEP) an instruction boundary must not stop execution.
    sel = 1'b0; cyc();
    sel = 1'b1; #1;
    n_cmp++; if (run !== 1'b1) begin n_bad++; $display("FAIL rs_boundary_run got %b want 1", run); end
    cyc();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rs_is_run got halted=%b want 0", halted); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_halt();
    test_step();
    test_breakpoint();
    test_resume_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Datapath stage directly downstream of the 8-phase instruction controller. Consumes its sel/ld_ir/inc_pc/ld_pc/halt strobes.
- Holds the program counter and instruction register, drives the memory address mux, and returns opcode to the controller.
- Adds a run/halt/single-step/breakpoint FSM whose run output is the controller's clock enable at top level.

Parameters:
AWIDTH, 5, PC / operand / memory address width
DWIDTH, 8, instruction width; opcode = IR[DWIDTH-1:AWIDTH]
CWIDTH, 16, retired-instruction counter width
START_HALTED, 0, 1 = leave reset in HALTED instead of RUN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
sel  in  1  address select from controller (1=PC, 0=IR operand)
ld_ir  in  1  load IR strobe from controller
inc_pc  in  1  increment PC strobe
ld_pc  in  1  load PC from IR operand strobe
halt  in  1  halt request from controller
data_in  in  DWIDTH  memory read data
resume  in  1  leave HALTED, free-run
step  in  1  leave HALTED, execute exactly one instruction
bp_en  in  1  breakpoint enable
bp_addr  in  AWIDTH  breakpoint PC value
opcode  out  DWIDTH-AWIDTH  IR opcode field, to controller
operand  out  AWIDTH  IR operand field
addr  out  AWIDTH  memory address
pc  out  AWIDTH  current PC
run  out  1  controller clock enable
halted  out  1  FSM in HALTED
bp_hit  out  1  sticky: last halt caused by breakpoint
instr_count  out  CWIDTH  IR captures since reset

Behaviour:
- Reset values:
  - pc=0, IR=0 (opcode=HLT, operand=0), instr_count=0, bp_hit=0.
  - sel_q=1, ld_ir_q=0, halt_q=0.
  - FSM=RUN, or HALTED if START_HALTED=1.
- Reset mid-operation clears everything immediately; there is no pending-state carryover.
- addr is combinational: sel ? pc : operand. It is valid in every state, including HALTED.
- Update qualifier: PC, IR and instr_count change only when run=1 in that cycle.
- PC update:
  - ld_pc has priority over inc_pc: pc <= operand.
  - Otherwise, inc_pc: pc <= pc+1, modulo 2^AWIDTH (31 wraps to 0).
- IR capture:
  - Captures data_in only on the first cycle of an ld_ir pulse (ld_ir & !ld_ir_q). The controller holds ld_ir for two phases and rd is low in the second, so the second-phase data is ignored.
  - Each capture increments instr_count, which wraps.
- Edge registers sel_q, ld_ir_q and halt_q sample every cycle, regardless of run.
- boundary = sel & !sel_q. This marks the start of a new instruction (STORE->INST_ADDR). It is never true out of reset.
- FSM states RUN, HALTED, STEP:
  - RUN -> HALTED when halt & !halt_q. inc_pc in the same cycle is still honoured, so PC ends past the HLT.
  - RUN -> HALTED when bp_en & boundary & pc==bp_addr; bp_hit <= 1.
  - HALTED -> RUN on resume; bp_hit <= 0.
  - HALTED -> STEP on step (no resume); bp_hit <= 0. resume wins if both are asserted.
  - STEP -> HALTED on boundary, which is the next instruction start. Breakpoints are ignored in STEP.
  - STEP -> HALTED on halt & !halt_q.
- run (combinational):
  - (RUN & !(bp_en & boundary & pc==bp_addr)) | (STEP & !boundary).
  - It drops in the same cycle as a breakpoint or step boundary, so the controller freezes in INST_ADDR.
  - On a halt edge, run is still 1 for that cycle. The controller advances one phase (to OP_FETCH) and then freezes.
- No re-trigger: while frozen, sel/halt stay constant, so sel_q/halt_q match them and no new edge is detected. resume therefore never immediately re-halts.
- halted = (FSM==HALTED).

Decomposition:
- Shared package risc_pkg:
  - opcode constants HLT..JMP;
  - AWIDTH/DWIDTH defaults;
  - run-FSM state enum {RUN, HALTED, STEP}.
- One sub-module, run_ctrl: the FSM, edge detectors, run/halted/bp_hit.
- fetch_unit contains PC, IR, counter and address mux.

Test Plan:
- Reset check: assert rst_n=0 mid-fetch with pc=7. Required: pc=0, opcode=0, instr_count=0, run=1, halted=0 asynchronously; addr=0 with sel=1.
- Sequential fetch: ld_ir held 2 cycles, data_in=0x45 then 0x99. Required: IR=0x45, opcode=2, operand=5, instr_count=1; inc_pc gives pc=1; ld_pc+inc_pc together give pc=5; inc_pc at pc=31 gives pc=0.
- Halt/resume: halt pulse with inc_pc at pc=3. Required: pc=4 and halted=1 next cycle; run=0; ld_pc/inc_pc ignored while halted, halt held high. resume gives run=1 with no re-halt.
- Single step: from HALTED, pulse step. Required: run=1 until the next sel 0->1 edge; run=0 in that cycle; halted=1 next cycle; exactly one IR capture (instr_count+1).
- Breakpoint: bp_en=1, bp_addr=6, program jumps to 6. Required: at the boundary with pc=6, run=0 the same cycle, halted=1 and bp_hit=1 next cycle. resume clears bp_hit and execution continues at 6 without re-hit.
- Simultaneous resume+step in HALTED: required FSM=RUN.
